// File: rtl/obstacle_pool.sv
// obstacle_pool: owns SLOTS obstacles. Spawns them, picks their type, size and gap,
// moves them every frame tick and frees them once they leave the screen.
module obstacle_pool #(
  parameter int SLOTS      = 3,
  parameter int MAX_DUP    = 2,
  parameter int GAME_WIDTH = 640,
  parameter int SCALE_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                update,
  input  logic                start,
  input  logic                crash,
  input  logic [14:0]         speed,
  input  logic [5:0]          timer,
  input  logic [10:0]         rng,
  input  logic [2:0]          req_type,
  output logic [1:0]          state,
  output logic [SLOTS-1:0]    active,
  output logic [11*SLOTS-1:0] x_pos,
  output logic [10*SLOTS-1:0] y_pos,
  output logic [3*SLOTS-1:0]  obs_type,
  output logic [2*SLOTS-1:0]  size,
  output logic [10*SLOTS-1:0] width,
  output logic [SLOTS-1:0]    frame,
  output logic                spawned
);

  typedef enum logic [1:0] {WAITING = 2'd0, RUNNING = 2'd1, CRASHED = 2'd2} state_t;

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [2:0] T_SMALL = 3'd1;
  localparam logic [2:0] T_LARGE = 3'd2;
  localparam logic [2:0] T_PTERO = 3'd3;
  localparam logic [14:0] PTERO_MIN_SPEED = 15'd8704;
  localparam logic signed [20:0] SPAWN_X = 21'(GAME_WIDTH << SCALE_LOG2);
  localparam logic signed [20:0] DRIFT = 21'sd819;
  localparam logic signed [12:0] GW13 = 13'(GAME_WIDTH);
  localparam logic [3:0] DUP_MAX = 4'(MAX_DUP);

  state_t state_q, state_d;
  logic [SLOTS-1:0] active_q, frame_q, up_q;
  logic signed [20:0] xg_q [SLOTS];
  logic [9:0] y_q [SLOTS];
  logic [2:0] type_q [SLOTS];
  logic [1:0] size_q [SLOTS];
  logic [9:0] width_q [SLOTS];
  logic [SW-1:0] last_q;
  logic [10:0] gap_q;
  logic [2:0] last_type_q;
  logic [3:0] dup_q;
  logic spawned_q;

  logic clear, run, spawn_now, any_live, has_free, room_ok, is_large, is_ptero, mult_hit;
  logic [SLOTS-1:0] pre_act, remove, live;
  logic signed [20:0] next_x [SLOTS];
  logic [SW-1:0] free_idx;
  logic signed [12:0] last_reach;
  logic [2:0] new_type;
  logic [3:0] new_dup;
  logic [1:0] new_size;
  logic [9:0] new_width, new_y, base_w;
  logic [10:0] new_gap;
  logic [24:0] gap_prod;
  logic [15:0] gap_sum;
  logic unused_rng;

  assign unused_rng = ^rng[3:0];

  function automatic logic wing(input logic [5:0] t);
    return (t >= 6'd10 && t < 6'd20) || (t >= 6'd30 && t < 6'd40) || (t >= 6'd50);
  endfunction

  function automatic logic signed [12:0] px13(input logic signed [20:0] xg);
    return 13'(signed'(xg[SCALE_LOG2 +: 11]));
  endfunction

  // Pool state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAITING;
    else        state_q <= state_d;
  end

  // Next pool state; crash always beats start, and slots are wiped when a run (re)starts
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    run     = 1'b0;
    if (update) begin
      case (state_q)
        WAITING: if (!crash && start) begin state_d = RUNNING; clear = 1'b1; run = 1'b1; end
        RUNNING: if (crash) state_d = CRASHED; else run = 1'b1;
        CRASHED: if (!crash && start) begin state_d = WAITING; clear = 1'b1; end
        default: state_d = WAITING;
      endcase
    end
  end

  // Per-slot removal and motion, then free-slot search and spacing check for the spawn
  always_comb begin
    pre_act  = clear ? '0 : active_q;
    remove   = '0;
    free_idx = '0;
    for (int i = 0; i < SLOTS; i++) begin
      next_x[i] = xg_q[i] - $signed({6'd0, speed})
                + ((type_q[i] == T_PTERO) ? (up_q[i] ? DRIFT : -DRIFT) : 21'sd0);
      if (run && pre_act[i] && (px13(xg_q[i]) + $signed({3'b000, width_q[i]}) <= 13'sd0))
        remove[i] = 1'b1;
    end
    live     = pre_act & ~remove;
    any_live = |live;
    has_free = ~&live;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (!live[i]) free_idx = SW'(i);
    last_reach = px13(xg_q[last_q]) + $signed({3'b000, width_q[last_q]}) + $signed({2'b00, gap_q});
    room_ok    = last_reach < GW13;
    spawn_now  = run && (req_type != 3'd0) && has_free && (!any_live || room_ok);
  end

  // Type substitution, duplicate tracking and the geometry/gap of the obstacle being spawned
  always_comb begin
    new_type = (req_type == T_PTERO && speed < PTERO_MIN_SPEED) ? T_SMALL : req_type;
    if (new_type == last_type_q && dup_q == DUP_MAX) begin
      case (new_type)
        T_SMALL: new_type = T_LARGE;
        T_LARGE: new_type = T_PTERO;
        default: new_type = T_SMALL;
      endcase
      if (new_type == T_PTERO && speed < PTERO_MIN_SPEED) new_type = T_SMALL;
    end
    new_dup  = (new_type != last_type_q) ? 4'd1 : (dup_q >= DUP_MAX) ? DUP_MAX : dup_q + 4'd1;
    is_large = (new_type == T_LARGE);
    is_ptero = (new_type == T_PTERO);
    mult_hit = is_ptero ? 1'b0 : is_large ? (speed > 15'd7168) : (speed > 15'd4096);
    new_size = mult_hit ? 2'(timer % 6'd3) + 2'd1 : 2'd1;
    base_w   = is_ptero ? 10'd46 : is_large ? 10'd25 : 10'd17;
    new_width = base_w * {8'd0, new_size};
    if (is_ptero)      new_y = (timer < 6'd20) ? 10'd100 : (timer < 6'd40) ? 10'd75 : 10'd50;
    else if (is_large) new_y = 10'd90;
    else               new_y = 10'd105;
    gap_prod = 25'(new_width) * 25'(speed);
    gap_sum  = 16'(gap_prod >> SCALE_LOG2) + (is_ptero ? 16'd150 : 16'd120) + {9'd0, rng[10:4]};
    new_gap  = (gap_sum > 16'd2047) ? 11'd2047 : gap_sum[10:0];
  end

  // Slot registers: wipe on (re)start, free/move on a running tick, then fill the spawn slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0; frame_q <= '0; up_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        xg_q[i] <= '0; y_q[i] <= '0; type_q[i] <= '0; size_q[i] <= '0; width_q[i] <= '0;
      end
      last_q <= '0; gap_q <= '0; last_type_q <= '0; dup_q <= '0; spawned_q <= 1'b0;
    end else begin
      spawned_q <= spawn_now;
      if (clear) begin
        active_q <= '0; frame_q <= '0; up_q <= '0;
        for (int i = 0; i < SLOTS; i++) begin
          xg_q[i] <= '0; y_q[i] <= '0; type_q[i] <= '0; size_q[i] <= '0; width_q[i] <= '0;
        end
      end
      for (int i = 0; i < SLOTS; i++) begin
        if (remove[i]) active_q[i] <= 1'b0;
        else if (run && pre_act[i]) begin
          xg_q[i] <= next_x[i];
          if (type_q[i] == T_PTERO) frame_q[i] <= wing(timer);
        end
      end
      if (spawn_now) begin
        active_q[free_idx] <= 1'b1;
        xg_q[free_idx]     <= SPAWN_X;
        y_q[free_idx]      <= new_y;
        type_q[free_idx]   <= new_type;
        size_q[free_idx]   <= new_size;
        width_q[free_idx]  <= new_width;
        frame_q[free_idx]  <= is_ptero & wing(timer);
        up_q[free_idx]     <= timer[0];
        last_q             <= free_idx;
        gap_q              <= new_gap;
        last_type_q        <= new_type;
        dup_q              <= new_dup;
      end
    end
  end

  // Pack slot registers onto the flat output buses
  always_comb begin
    state    = state_q;
    active   = active_q;
    frame    = frame_q;
    spawned  = spawned_q;
    x_pos    = '0;
    y_pos    = '0;
    obs_type = '0;
    size     = '0;
    width    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      x_pos[i*11 +: 11]   = xg_q[i][SCALE_LOG2 +: 11];
      y_pos[i*10 +: 10]   = y_q[i];
      obs_type[i*3 +: 3]  = type_q[i];
      size[i*2 +: 2]      = size_q[i];
      width[i*10 +: 10]   = width_q[i];
    end
  end

endmodule

// File: tb/tb_obstacle_pool.sv
// tb_obstacle_pool: drives directed and random frame ticks into a 2-slot pool and
// compares every cycle against a reference model through an expectation queue.
module tb_obstacle_pool;
  localparam int NS = 2;
  localparam int MAXD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0, update = 1'b0, start = 1'b0, crash = 1'b0;
  logic [14:0] speed = '0;
  logic [5:0] timer = '0;
  logic [10:0] rng = '0;
  logic [2:0] req_type = '0;
  logic [1:0] state;
  logic [NS-1:0] active, frame;
  logic [11*NS-1:0] x_pos;
  logic [10*NS-1:0] y_pos, width;
  logic [3*NS-1:0] obs_type;
  logic [2*NS-1:0] size;
  logic spawned;

  obstacle_pool #(.SLOTS(NS), .MAX_DUP(MAXD), .GAME_WIDTH(640), .SCALE_LOG2(10)) dut (
    .clk(clk), .rst_n(rst_n), .update(update), .start(start), .crash(crash),
    .speed(speed), .timer(timer), .rng(rng), .req_type(req_type),
    .state(state), .active(active), .x_pos(x_pos), .y_pos(y_pos), .obs_type(obs_type),
    .size(size), .width(width), .frame(frame), .spawned(spawned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st; logic [NS-1:0] act; logic [11*NS-1:0] x; logic [10*NS-1:0] y;
    logic [3*NS-1:0] ty; logic [2*NS-1:0] sz; logic [10*NS-1:0] w; logic [NS-1:0] fr; logic sp;
  } snap_t;

  snap_t exp_q[$];
  int errors = 0, checks = 0, cycle = 0, tmr = 0;

  // Reference model: game state kept as plain integers (x in 1/1024 pixel units)
  int m_state, m_last, m_gap, m_last_type, m_dup;
  bit m_spawned;
  int m_act[NS], m_xg[NS], m_y[NS], m_typ[NS], m_size[NS], m_w[NS], m_fr[NS], m_up[NS];

  function automatic int model_wing(input int t);
    return ((t / 10) % 2 == 1) ? 1 : 0;
  endfunction

  function automatic int mult_of(input int t);
    return (t == 1) ? 4096 : (t == 2) ? 7168 : 1022976;
  endfunction

  task automatic model_clear_slots();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_xg[i] = 0; m_y[i] = 0; m_typ[i] = 0;
      m_size[i] = 0; m_w[i] = 0; m_fr[i] = 0; m_up[i] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear_slots();
    m_state = 0; m_last = 0; m_gap = 0; m_last_type = 0; m_dup = 0; m_spawned = 0;
  endtask

  task automatic model_step(input bit upd, input bit st, input bit cr,
                            input int spd, input int tm, input int rn, input int rq);
    int prev, lastx, lastw, nact, fidx, t;
    bit clr, run;
    m_spawned = 0;
    if (!upd) return;
    prev = m_state; clr = 0; run = 0;
    if (cr) begin
      if (prev == 1) m_state = 2;
    end else if (st && prev == 0) begin
      clr = 1; run = 1; m_state = 1;
    end else if (st && prev == 2) begin
      clr = 1; m_state = 0;
    end else if (prev == 1) run = 1;
    if (clr) model_clear_slots();
    if (!run) return;
    lastx = m_xg[m_last] >>> 10;
    lastw = m_w[m_last];
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] != 0) begin
        if ((m_xg[i] >>> 10) + m_w[i] <= 0) m_act[i] = 0;
        else begin
          m_xg[i] = m_xg[i] - spd + ((m_typ[i] == 3) ? ((m_up[i] != 0) ? 819 : -819) : 0);
          if (m_typ[i] == 3) m_fr[i] = model_wing(tm);
        end
      end
    end
    nact = 0; fidx = -1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (m_act[i] != 0) nact++;
      else fidx = i;
    end
    if (rq == 0 || fidx < 0 || (nact != 0 && lastx + lastw + m_gap >= 640)) return;
    t = rq;
    if (t == 3 && spd < 8704) t = 1;
    if (t == m_last_type && m_dup == MAXD) begin
      t = t % 3 + 1;
      if (t == 3 && spd < 8704) t = 1;
    end
    m_dup = (t == m_last_type) ? ((m_dup < MAXD) ? m_dup + 1 : MAXD) : 1;
    m_last_type = t;
    m_act[fidx]  = 1;
    m_xg[fidx]   = 640 * 1024;
    m_typ[fidx]  = t;
    m_size[fidx] = (spd > mult_of(t)) ? tm % 3 + 1 : 1;
    m_w[fidx]    = ((t == 1) ? 17 : (t == 2) ? 25 : 46) * m_size[fidx];
    m_y[fidx]    = (t == 1) ? 105 : (t == 2) ? 90 : (tm < 20) ? 100 : (tm < 40) ? 75 : 50;
    m_fr[fidx]   = (t == 3) ? model_wing(tm) : 0;
    m_up[fidx]   = tm % 2;
    m_gap        = m_w[fidx] * spd / 1024 + ((t == 3) ? 150 : 120) + rn / 16;
    if (m_gap > 2047) m_gap = 2047;
    m_last       = fidx;
    m_spawned    = 1;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    s.st = 2'(m_state);
    s.sp = m_spawned;
    for (int i = 0; i < NS; i++) begin
      s.act[i] = (m_act[i] != 0);
      s.fr[i]  = (m_fr[i] != 0);
      s.x[i*11 +: 11] = 11'(m_xg[i] >>> 10);
      s.y[i*10 +: 10] = 10'(m_y[i]);
      s.ty[i*3 +: 3]  = 3'(m_typ[i]);
      s.sz[i*2 +: 2]  = 2'(m_size[i]);
      s.w[i*10 +: 10] = 10'(m_w[i]);
    end
    return s;
  endfunction

  // Drive one clock cycle of inputs at the falling edge and queue the expected result
  task automatic apply_stimulus(input bit rst, input bit upd, input bit st, input bit cr,
                                input int spd, input int rq, input int rn);
    @(negedge clk);
    rst_n = !rst; update = upd; start = st; crash = cr;
    speed = 15'(spd); timer = 6'(tmr); rng = 11'(rn); req_type = 3'(rq);
    if (rst) model_reset();
    else model_step(upd, st, cr, spd, tmr, rn, rq);
    exp_q.push_back(model_snap());
    if (upd && !rst) tmr = (tmr + 1) % 60;
  endtask

  task automatic run_ticks(input int n, input int spd, input int rq, input int rn);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, spd, rq, rn);
  endtask

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cycle, got, want);
    end
  endtask

  // Monitor: shortly after every rising edge pop one expectation and compare all outputs
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #2;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("state", 64'(state), 64'(e.st));
        check_output("active", 64'(active), 64'(e.act));
        check_output("x_pos", 64'(x_pos), 64'(e.x));
        check_output("y_pos", 64'(y_pos), 64'(e.y));
        check_output("obs_type", 64'(obs_type), 64'(e.ty));
        check_output("size", 64'(size), 64'(e.sz));
        check_output("width", 64'(width), 64'(e.w));
        check_output("frame", 64'(frame), 64'(e.fr));
        check_output("spawned", 64'(spawned), 64'(e.sp));
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized soak
  initial begin
    model_reset();
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    // first spawn straight out of start
    tmr = 3;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 6144, 1, 0);
    // idle cycles with noisy inputs must change nothing
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 20000, 3, 2047);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 100, 2, 5);
    // motion and removal of the lone cactus
    run_ticks(70, 10240, 0, 0);
    // pterodactyl gated to a small cactus at low speed, then let it leave
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8000, 3, 64);
    run_ticks(125, 8000, 0, 0);
    // real pterodactyl at timer 25, watch the wing frame flip at 30 and 40
    tmr = 25;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 9216, 3, 0);
    run_ticks(30, 9216, 0, 0);
    // held small-cactus request at slow speed: duplicate rotation, gaps and a full pool
    run_ticks(450, 2048, 1, 0);
    // crash freezes, simultaneous crash+start stays crashed, start then returns to waiting
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 2048, 1, 0);
    run_ticks(10, 6000, 1, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 6000, 1, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 6000, 1, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 6000, 1, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 12000, 2, 300);
    run_ticks(20, 12000, 2, 300);
    // reset in the middle of a run
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12000, 2, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 12000, 3, 0);
    // randomized soak
    for (int k = 0; k < 1500; k++) begin
      apply_stimulus(($urandom % 700) == 0, ($urandom % 4) != 0, ($urandom % 40) == 0,
                     ($urandom % 150) == 0, int'($urandom_range(1000, 20000)),
                     int'($urandom % 4), int'($urandom % 2048));
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
